id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/otter_pkg.sv | 52 +++++
 rtl/load_use_detect.sv | 31 +++
 rtl/id_ex_stage.sv | 152 +++++++++++++++
 tb/tb_id_ex_stage.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared OTTER pipeline types: operand-select encodings, control bundle and EX register layout.
package otter_pkg;

  typedef enum logic [1:0] {
    AluSrcbReg  = 2'b00,
    AluSrcbImmI = 2'b01,
    AluSrcbImmS = 2'b10,
    AluSrcbImmU = 2'b11
  } alu_srcb_e;

  typedef enum logic [1:0] {
    RfSelPc4 = 2'b00,
    RfSelCsr = 2'b01,
    RfSelMem = 2'b10,
    RfSelAlu = 2'b11
  } rf_sel_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read2;
    logic [1:0] rf_sel;
    logic [3:0] alu_fun;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic [2:0] func3;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
  } ex_data_t;

  // A bubble only needs the enables low; zeroing the whole bundle keeps EX quiet.
  localparam ctrl_t CtrlBubble = '0;

  function automatic logic rs1_used(logic alu_srca);
    return ~alu_srca;
  endfunction

  function automatic logic rs2_used(logic [1:0] alu_srcb, logic mem_write);
    return (alu_srcb == AluSrcbReg) | mem_write;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the sources used in ID.
// Only compiled when ID_EX_LOAD_USE_EN is defined.
`ifdef ID_EX_LOAD_USE_EN
module load_use_detect
  import otter_pkg::*;
(
  input  logic       ex_valid_i,
  input  logic       ex_mem_read2_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic       id_valid_i,
  input  logic       id_alu_srca_i,
  input  logic [1:0] id_alu_srcb_i,
  input  logic       id_mem_write_i,
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  output logic       hazard_o
);

  logic load_in_ex;
  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    load_in_ex = ex_valid_i & ex_mem_read2_i & (ex_rd_addr_i != 5'd0);
    rs1_hit    = rs1_used(id_alu_srca_i) & (id_rs1_addr_i == ex_rd_addr_i);
    rs2_hit    = rs2_used(id_alu_srcb_i, id_mem_write_i) & (id_rs2_addr_i == ex_rd_addr_i);
    hazard_o   = load_in_ex & id_valid_i & (rs1_hit | rs2_hit);
  end

endmodule
`endif

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush/hold/bubble priority and optional load-use stall.
// Load-use detection is enabled by defining ID_EX_LOAD_USE_EN.
module id_ex_stage
  import otter_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        id_valid_i,
  input  logic [31:0] id_pc_i,
  input  logic [31:0] id_rs1_data_i,
  input  logic [31:0] id_rs2_data_i,
  input  logic [31:0] id_imm_i_i,
  input  logic [31:0] id_imm_s_i,
  input  logic [31:0] id_imm_u_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic [4:0]  id_rd_addr_i,
  input  logic        id_reg_write_i,
  input  logic        id_mem_write_i,
  input  logic        id_mem_read2_i,
  input  logic [1:0]  id_rf_sel_i,
  input  logic [3:0]  id_alu_fun_i,
  input  logic        id_alu_srca_i,
  input  logic [1:0]  id_alu_srcb_i,
  input  logic [2:0]  id_func3_i,
  input  logic        flush_i,
  input  logic        ex_hold_i,
  output logic        stall_id_o,
  output logic        ex_valid_o,
  output logic [31:0] ex_pc_o,
  output logic [31:0] ex_rs1_data_o,
  output logic [31:0] ex_rs2_data_o,
  output logic [31:0] ex_imm_i_o,
  output logic [31:0] ex_imm_s_o,
  output logic [31:0] ex_imm_u_o,
  output logic [4:0]  ex_rs1_addr_o,
  output logic [4:0]  ex_rs2_addr_o,
  output logic [4:0]  ex_rd_addr_o,
  output logic        ex_reg_write_o,
  output logic        ex_mem_write_o,
  output logic        ex_mem_read2_o,
  output logic [1:0]  ex_rf_sel_o,
  output logic [3:0]  ex_alu_fun_o,
  output logic        ex_alu_srca_o,
  output logic [1:0]  ex_alu_srcb_o,
  output logic [2:0]  ex_func3_o
);

  ctrl_t    id_ctrl;
  ex_data_t id_data;
  logic     valid_d, valid_q;
  ctrl_t    ctrl_d, ctrl_q;
  ex_data_t data_d, data_q;
  logic     hazard;

  assign id_ctrl = '{
    reg_write: id_reg_write_i,
    mem_write: id_mem_write_i,
    mem_read2: id_mem_read2_i,
    rf_sel:    id_rf_sel_i,
    alu_fun:   id_alu_fun_i,
    alu_srca:  id_alu_srca_i,
    alu_srcb:  id_alu_srcb_i,
    func3:     id_func3_i
  };

  assign id_data = '{
    pc:       id_pc_i,
    rs1_data: id_rs1_data_i,
    rs2_data: id_rs2_data_i,
    imm_i:    id_imm_i_i,
    imm_s:    id_imm_s_i,
    imm_u:    id_imm_u_i,
    rs1_addr: id_rs1_addr_i,
    rs2_addr: id_rs2_addr_i,
    rd_addr:  id_rd_addr_i
  };

`ifdef ID_EX_LOAD_USE_EN
  load_use_detect u_load_use_detect (
    .ex_valid_i     (valid_q),
    .ex_mem_read2_i (ctrl_q.mem_read2),
    .ex_rd_addr_i   (data_q.rd_addr),
    .id_valid_i     (id_valid_i),
    .id_alu_srca_i  (id_alu_srca_i),
    .id_alu_srcb_i  (id_alu_srcb_i),
    .id_mem_write_i (id_mem_write_i),
    .id_rs1_addr_i  (id_rs1_addr_i),
    .id_rs2_addr_i  (id_rs2_addr_i),
    .hazard_o       (hazard)
  );
`else
  assign hazard = 1'b0;
`endif

  // Flush dominates so a taken branch never leaves a stall behind.
  assign stall_id_o = (hazard | ex_hold_i) & ~flush_i;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = CtrlBubble;
    end else if (!ex_hold_i) begin
      if (hazard) begin
        valid_d = 1'b0;
        ctrl_d  = CtrlBubble;
      end else begin
        valid_d           = id_valid_i;
        ctrl_d            = id_ctrl;
        ctrl_d.reg_write  = id_valid_i & id_reg_write_i & (id_rd_addr_i != 5'd0);
        ctrl_d.mem_write  = id_valid_i & id_mem_write_i;
        ctrl_d.mem_read2  = id_valid_i & id_mem_read2_i;
        data_d            = id_data;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign ex_valid_o     = valid_q;
  assign ex_pc_o        = data_q.pc;
  assign ex_rs1_data_o  = data_q.rs1_data;
  assign ex_rs2_data_o  = data_q.rs2_data;
  assign ex_imm_i_o     = data_q.imm_i;
  assign ex_imm_s_o     = data_q.imm_s;
  assign ex_imm_u_o     = data_q.imm_u;
  assign ex_rs1_addr_o  = data_q.rs1_addr;
  assign ex_rs2_addr_o  = data_q.rs2_addr;
  assign ex_rd_addr_o   = data_q.rd_addr;
  assign ex_reg_write_o = ctrl_q.reg_write;
  assign ex_mem_write_o = ctrl_q.mem_write;
  assign ex_mem_read2_o = ctrl_q.mem_read2;
  assign ex_rf_sel_o    = ctrl_q.rf_sel;
  assign ex_alu_fun_o   = ctrl_q.alu_fun;
  assign ex_alu_srca_o  = ctrl_q.alu_srca;
  assign ex_alu_srcb_o  = ctrl_q.alu_srcb;
  assign ex_func3_o     = ctrl_q.func3;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic against a model.
module tb_id_ex_stage;

`ifdef ID_EX_LOAD_USE_EN
  localparam bit LuEn = 1'b1;
`else
  localparam bit LuEn = 1'b0;
`endif

  typedef struct packed {
    logic        valid;
    logic        regw;
    logic        memw;
    logic        memr;
    logic [1:0]  rf;
    logic [3:0]  fun;
    logic        srca;
    logic [1:0]  srcb;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] immi;
    logic [31:0] imms;
    logic [31:0] immu;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [4:0]  rd;
  } ex_t;

  localparam ex_t BubbleMask = {4'hf, {219{1'b0}}};

  logic clk, rst_n;
  logic id_valid, id_regw, id_memw, id_memr, id_srca, flush, ex_hold;
  logic [31:0] id_pc, id_rs1d, id_rs2d, id_immi, id_imms, id_immu;
  logic [4:0]  id_rs1a, id_rs2a, id_rd;
  logic [1:0]  id_rf, id_srcb;
  logic [3:0]  id_fun;
  logic [2:0]  id_f3;

  logic        stall_id, ex_valid, ex_regw, ex_memw, ex_memr, ex_srca;
  logic [31:0] ex_pc, ex_rs1d, ex_rs2d, ex_immi, ex_imms, ex_immu;
  logic [4:0]  ex_rs1a, ex_rs2a, ex_rd;
  logic [1:0]  ex_rf, ex_srcb;
  logic [3:0]  ex_fun;
  logic [2:0]  ex_f3;

  ex_t  m;
  bit   m_known;
  logic obs_stall, exp_stall;
  int   checks = 0;
  int   failures = 0;

  id_ex_stage dut (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid),
    .id_pc_i(id_pc), .id_rs1_data_i(id_rs1d), .id_rs2_data_i(id_rs2d),
    .id_imm_i_i(id_immi), .id_imm_s_i(id_imms), .id_imm_u_i(id_immu),
    .id_rs1_addr_i(id_rs1a), .id_rs2_addr_i(id_rs2a), .id_rd_addr_i(id_rd),
    .id_reg_write_i(id_regw), .id_mem_write_i(id_memw), .id_mem_read2_i(id_memr),
    .id_rf_sel_i(id_rf), .id_alu_fun_i(id_fun), .id_alu_srca_i(id_srca),
    .id_alu_srcb_i(id_srcb), .id_func3_i(id_f3), .flush_i(flush), .ex_hold_i(ex_hold),
    .stall_id_o(stall_id), .ex_valid_o(ex_valid),
    .ex_pc_o(ex_pc), .ex_rs1_data_o(ex_rs1d), .ex_rs2_data_o(ex_rs2d),
    .ex_imm_i_o(ex_immi), .ex_imm_s_o(ex_imms), .ex_imm_u_o(ex_immu),
    .ex_rs1_addr_o(ex_rs1a), .ex_rs2_addr_o(ex_rs2a), .ex_rd_addr_o(ex_rd),
    .ex_reg_write_o(ex_regw), .ex_mem_write_o(ex_memw), .ex_mem_read2_o(ex_memr),
    .ex_rf_sel_o(ex_rf), .ex_alu_fun_o(ex_fun), .ex_alu_srca_o(ex_srca),
    .ex_alu_srcb_o(ex_srcb), .ex_func3_o(ex_f3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic ex_t id_vec();
    return '{valid: id_valid, regw: id_regw, memw: id_memw, memr: id_memr, rf: id_rf,
             fun: id_fun, srca: id_srca, srcb: id_srcb, f3: id_f3, pc: id_pc, rs1d: id_rs1d,
             rs2d: id_rs2d, immi: id_immi, imms: id_imms, immu: id_immu, rs1a: id_rs1a,
             rs2a: id_rs2a, rd: id_rd};
  endfunction

  function automatic ex_t dut_vec();
    return '{valid: ex_valid, regw: ex_regw, memw: ex_memw, memr: ex_memr, rf: ex_rf,
             fun: ex_fun, srca: ex_srca, srcb: ex_srcb, f3: ex_f3, pc: ex_pc, rs1d: ex_rs1d,
             rs2d: ex_rs2d, immi: ex_immi, imms: ex_imms, immu: ex_immu, rs1a: ex_rs1a,
             rs2a: ex_rs2a, rd: ex_rd};
  endfunction

  function automatic ex_t cur_mask();
    return m_known ? '1 : BubbleMask;
  endfunction

  // A live load in EX whose destination the ID instruction actually reads.
  function automatic bit model_hazard();
    ex_t  id = id_vec();
    bit   reads_rs1 = (id.srca == 1'b0) && (id.rs1a == m.rd);
    bit   reads_rs2 = ((id.srcb == 2'b00) || id.memw) && (id.rs2a == m.rd);
    return LuEn && m.valid && m.memr && (m.rd != 5'd0) && id.valid && (reads_rs1 || reads_rs2);
  endfunction

  task automatic model_step();
    ex_t id = id_vec();
    bit  hz = model_hazard();
    if (flush || (!ex_hold && hz)) begin
      m.valid = 1'b0; m.regw = 1'b0; m.memw = 1'b0; m.memr = 1'b0;
      m_known = 1'b0;
    end else if (!ex_hold) begin
      m = id;
      m.regw = id.valid && id.regw && (id.rd != 5'd0);
      m.memw = id.valid && id.memw;
      m.memr = id.valid && id.memr;
      m_known = 1'b1;
    end
  endtask

  // Samples STALL_ID mid-cycle, advances the model and the clock, returns #1 after the edge.
  task automatic cycle();
    @(negedge clk);
    obs_stall = stall_id;
    exp_stall = !flush && (ex_hold || model_hazard());
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic regw, input logic memw,
                           input logic memr, input logic srca, input logic [1:0] srcb);
    id_valid = v; id_rd = rd; id_rs1a = rs1; id_rs2a = rs2;
    id_regw = regw; id_memw = memw; id_memr = memr; id_srca = srca; id_srcb = srcb;
    id_pc = $urandom; id_rs1d = $urandom; id_rs2d = $urandom;
    id_immi = $urandom; id_imms = $urandom; id_immu = $urandom;
    id_rf = 2'($urandom); id_fun = 4'($urandom); id_f3 = 3'($urandom);
  endtask

  task automatic rand_instr();
    logic [4:0] a [3];
    for (int i = 0; i < 3; i++) a[i] = ($urandom_range(9, 0) < 7) ? 5'($urandom_range(3, 0))
                                                                   : 5'($urandom);
    set_instr(($urandom_range(99, 0) < 85), a[0], a[1], a[2], 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 2'($urandom));
  endtask

  task automatic test_reset();
    flush = 1'b0; ex_hold = 1'b0;
    rand_instr();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (dut_vec() !== '0) begin
      failures++; $display("FAIL por_outputs: got %h expected 0", dut_vec());
    end
    checks++;
    if (stall_id !== 1'b0) begin
      failures++; $display("FAIL por_stall: got %b expected 0", stall_id);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      failures++; $display("FAIL por_edge_in_reset: got %h expected 0", dut_vec());
    end
    #2 rst_n = 1'b1;
    m = '0; m_known = 1'b1;
  endtask

  task automatic test_pass_through();
    // ADDI x5, x0, 7
    set_instr(1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
    id_immi = 32'd7;
    cycle();
    checks++;
    if (obs_stall !== 1'b0) begin
      failures++; $display("FAIL addi_stall: got %b expected 0", obs_stall);
    end
    checks++;
    if ({ex_valid, ex_regw, ex_rd, ex_immi} !== {1'b1, 1'b1, 5'd5, 32'd7}) begin
      failures++;
      $display("FAIL addi_ex: got v=%b rw=%b rd=%0d imm=%0d expected v=1 rw=1 rd=5 imm=7",
               ex_valid, ex_regw, ex_rd, ex_immi);
    end
  endtask

  task automatic test_async_reset();
    // LW x6, 0(x2) then reset mid-cycle with ADD x7,x6,x1 waiting in ID
    set_instr(1'b1, 5'd6, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01);
    cycle();
    checks++;
    if (ex_valid !== 1'b1) begin
      failures++; $display("FAIL arst_pre_valid: got %b expected 1", ex_valid);
    end
    #2 rst_n = 1'b0;
    set_instr(1'b1, 5'd7, 5'd6, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      failures++; $display("FAIL arst_outputs: got %h expected 0", dut_vec());
    end
    checks++;
    if (stall_id !== 1'b0) begin
      failures++; $display("FAIL arst_stall: got %b expected 0", stall_id);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    m = '0; m_known = 1'b1;
    cycle();
    checks++;
    if (obs_stall !== 1'b0) begin
      failures++; $display("FAIL arst_no_stale_hazard: got %b expected 0", obs_stall);
    end
    checks++;
    if ({ex_valid, ex_rd} !== {1'b1, 5'd7}) begin
      failures++; $display("FAIL arst_first_capture: got v=%b rd=%0d expected v=1 rd=7",
                           ex_valid, ex_rd);
    end
  endtask

  task automatic test_load_use();
    set_instr(1'b1, 5'd6, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01);
    cycle();
    set_instr(1'b1, 5'd7, 5'd6, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    cycle();
    checks++;
    if (obs_stall !== LuEn) begin
      failures++; $display("FAIL lu_stall: got %b expected %b", obs_stall, LuEn);
    end
    checks++;
    if (ex_valid !== !LuEn) begin
      failures++; $display("FAIL lu_bubble: got ex_valid=%b expected %b", ex_valid, !LuEn);
    end
    cycle();
    checks++;
    if (obs_stall !== 1'b0) begin
      failures++; $display("FAIL lu_one_cycle: got %b expected 0", obs_stall);
    end
    checks++;
    if ({ex_valid, ex_regw, ex_rd} !== {1'b1, 1'b1, 5'd7}) begin
      failures++; $display("FAIL lu_add_in_ex: got v=%b rw=%b rd=%0d expected v=1 rw=1 rd=7",
                           ex_valid, ex_regw, ex_rd);
    end
  endtask

  task automatic test_no_false_hazard();
    // LW x0 then ADD x7,x0,x0
    set_instr(1'b1, 5'd0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01);
    cycle();
    checks++;
    if (ex_regw !== 1'b0) begin
      failures++; $display("FAIL x0_regwrite: got %b expected 0", ex_regw);
    end
    set_instr(1'b1, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    cycle();
    checks++;
    if (obs_stall !== 1'b0) begin
      failures++; $display("FAIL x0_no_stall: got %b expected 0", obs_stall);
    end
    // LW x6 then LUI x6 whose raw rs fields alias x6
    set_instr(1'b1, 5'd6, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01);
    cycle();
    set_instr(1'b1, 5'd6, 5'd6, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11);
    cycle();
    checks++;
    if (obs_stall !== 1'b0) begin
      failures++; $display("FAIL lui_no_stall: got %b expected 0", obs_stall);
    end
  endtask

  task automatic test_flush_priority();
    set_instr(1'b1, 5'd6, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01);
    cycle();
    set_instr(1'b1, 5'd7, 5'd6, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    flush = 1'b1; ex_hold = 1'b1;
    cycle();
    checks++;
    if (obs_stall !== 1'b0) begin
      failures++; $display("FAIL flush_stall: got %b expected 0", obs_stall);
    end
    checks++;
    if ({ex_valid, ex_regw, ex_memw, ex_memr} !== 4'b0000) begin
      failures++; $display("FAIL flush_bubble: got %b expected 0000",
                           {ex_valid, ex_regw, ex_memw, ex_memr});
    end
    flush = 1'b0; ex_hold = 1'b0;
    cycle();
    checks++;
    if (obs_stall !== 1'b0) begin
      failures++; $display("FAIL flush_residual: got %b expected 0", obs_stall);
    end
  endtask

  task automatic test_hold();
    logic [31:0] held_pc;
    set_instr(1'b1, 5'd9, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01);
    held_pc = id_pc;
    cycle();
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_instr();
      cycle();
      checks++;
      if (obs_stall !== 1'b1) begin
        failures++; $display("FAIL hold_stall[%0d]: got %b expected 1", i, obs_stall);
      end
      checks++;
      if ({ex_valid, ex_rd, ex_pc} !== {1'b1, 5'd9, held_pc}) begin
        failures++; $display("FAIL hold_frozen[%0d]: got v=%b rd=%0d pc=%h expected v=1 rd=9 pc=%h",
                             i, ex_valid, ex_rd, ex_pc, held_pc);
      end
      checks++;
      if ((dut_vec() & cur_mask()) !== (m & cur_mask())) begin
        failures++; $display("FAIL hold_model[%0d]: got %h expected %h", i, dut_vec(), m);
      end
    end
    ex_hold = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      flush   = ($urandom_range(9, 0) == 0);
      ex_hold = ($urandom_range(6, 0) == 0);
      rand_instr();
      cycle();
      checks++;
      if (obs_stall !== exp_stall) begin
        failures++; $display("FAIL rand_stall[%0d]: got %b expected %b", i, obs_stall, exp_stall);
      end
      checks++;
      if ((dut_vec() & cur_mask()) !== (m & cur_mask())) begin
        failures++; $display("FAIL rand_ex[%0d]: got %h expected %h (mask %h)",
                             i, dut_vec(), m, cur_mask());
      end
    end
    flush = 1'b0; ex_hold = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    m = '0; m_known = 1'b1;
    test_reset();
    test_pass_through();
    test_async_reset();
    test_load_use();
    test_no_false_hazard();
    test_flush_priority();
    test_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
